// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift 8 data + parity + stop, sample ACK.
// Open-drain outputs (oe=1 pulls the line low); both lines are conditioned by a 2-FF sync and an agreement filter.
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ    = 25000000,
  parameter int INHIBIT_US     = 120,
  parameter int FIRST_EDGE_MS  = 15,
  parameter int BIT_TIMEOUT_US = 2000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic [1:0] err_code,
  input  logic       ps2clk_i,
  input  logic       ps2data_i,
  output logic       ps2clk_oe,
  output logic       ps2data_oe
);

  localparam int US          = CLK_FREQ_HZ / 1000000;
  localparam int INHIBIT_CYC = INHIBIT_US * US;
  localparam int REQ_CYC     = US;
  localparam int FIRST_CYC   = FIRST_EDGE_MS * 1000 * US;
  localparam int BIT_CYC     = BIT_TIMEOUT_US * US;
  localparam int TMAX_A      = (FIRST_CYC > BIT_CYC) ? FIRST_CYC : BIT_CYC;
  localparam int TMAX        = (TMAX_A > INHIBIT_CYC) ? TMAX_A : INHIBIT_CYC;
  localparam int TW          = $clog2(TMAX + 1);
  localparam int FW          = $clog2(FILTER_LEN + 1);

  localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYC - 1);
  localparam logic [TW-1:0] REQ_LAST     = TW'(REQ_CYC - 1);
  localparam logic [TW-1:0] FIRST_LAST   = TW'(FIRST_CYC - 1);
  localparam logic [TW-1:0] BIT_LAST     = TW'(BIT_CYC - 1);
  localparam logic [FW-1:0] FILT_LAST    = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_RELEASE, S_DONE
  } state_t;

  // Bit 0 carries the clock line, bit 1 the data line.
  logic [1:0]    sync1, sync2, filt, filt_q;
  logic [FW-1:0] fcnt [2];
  logic          clk_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      filt    <= 2'b11;
      filt_q  <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      sync1  <= {ps2data_i, ps2clk_i};
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FILT_LAST) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign clk_fall = filt_q[0] & ~filt[0];

  state_t        state;
  logic [7:0]    data_q;
  logic          parity;
  logic [3:0]    n;
  logic [TW-1:0] timer;
  logic [1:0]    ack_code;
  logic [TW-1:0] shift_last;

  // Only the wait for the first fall gets the long limit.
  assign shift_last = (n == 4'd0) ? FIRST_LAST : BIT_LAST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      data_q     <= '0;
      parity     <= 1'b0;
      n          <= '0;
      timer      <= '0;
      ack_code   <= 2'b00;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_code   <= 2'b00;
      ps2clk_oe  <= 1'b0;
      ps2data_oe <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_valid && tx_ready) begin
            data_q    <= tx_data;
            parity    <= ~^tx_data;
            n         <= '0;
            timer     <= '0;
            ps2clk_oe <= 1'b1;
            tx_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (timer == INHIBIT_LAST) begin
            timer      <= '0;
            ps2data_oe <= 1'b1;
            state      <= S_REQ;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_REQ: begin
          if (timer == REQ_LAST) begin
            timer     <= '0;
            ps2clk_oe <= 1'b0;
            state     <= S_SHIFT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_SHIFT: begin
          if (clk_fall) begin
            timer <= '0;
            n     <= n + 1'b1;
            if (n < 4'd8) begin
              ps2data_oe <= ~data_q[n[2:0]];
            end else if (n == 4'd8) begin
              ps2data_oe <= ~parity;
            end else begin
              ps2data_oe <= 1'b0;
              state      <= S_ACK;
            end
          end else if (timer == shift_last) begin
            ps2clk_oe  <= 1'b0;
            ps2data_oe <= 1'b0;
            err_code   <= (n == 4'd0) ? 2'b01 : 2'b10;
            done       <= 1'b1;
            state      <= S_DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_ACK: begin
          if (clk_fall) begin
            ack_code <= filt[1] ? 2'b11 : 2'b00;
            timer    <= '0;
            state    <= S_RELEASE;
          end else if (timer == BIT_LAST) begin
            err_code <= 2'b10;
            done     <= 1'b1;
            state    <= S_DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RELEASE: begin
          if (&filt) begin
            err_code <= ack_code;
            done     <= 1'b1;
            state    <= S_DONE;
          end else if (timer == BIT_LAST) begin
            err_code <= 2'b10;
            done     <= 1'b1;
            state    <= S_DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DONE: begin
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model, a device model that clocks and ACKs,
// and scoreboard queues of expected frame bits and completion codes.
module tb_ps2_host_tx;

  localparam int US    = 2;
  localparam int INH   = 120 * US;
  localparam int FIRST = 15 * 1000 * US;
  localparam int BITC  = 2000 * US;
  localparam int HALF  = 80;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, done;
  logic [1:0] err_code;
  logic       ps2clk_i, ps2data_i, ps2clk_oe, ps2data_oe;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch = 1'b0;

  int total = 0, bad = 0;
  int cyc = 0, done_cnt = 0, fall5_cyc = 0, done_cyc = 0;
  int clk_run = 0, both_run = 0, last_clk_low = 0, last_both_low = 0;
  logic       exp_bits [$];
  logic [1:0] exp_err  [$];

  always #5 clk = ~clk;

  assign ps2clk_i  = !(ps2clk_oe || dev_clk_low || glitch);
  assign ps2data_i = !(ps2data_oe || dev_data_low);

  ps2_host_tx #(.CLK_FREQ_HZ(US * 1000000)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .err_code(err_code),
    .ps2clk_i(ps2clk_i), .ps2data_i(ps2data_i),
    .ps2clk_oe(ps2clk_oe), .ps2data_oe(ps2data_oe)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  // Length of the last host clock-low stretch and how much of it had data low too.
  always @(negedge clk) begin
    if (ps2clk_oe) begin
      clk_run  <= clk_run + 1;
      both_run <= both_run + (ps2data_oe ? 1 : 0);
    end else begin
      if (clk_run != 0) begin
        last_clk_low  <= clk_run;
        last_both_low <= both_run;
      end
      clk_run  <= 0;
      both_run <= 0;
    end
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] b);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    exp_bits.push_back(($countones(b) % 2) == 0);
    exp_bits.push_back(1'b1);
  endtask

  task automatic send(input logic [7:0] b);
    int w = 0;
    while (!tx_ready && w < 1000) begin tick(1); w++; end
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit, output int cycles);
    logic [1:0] e;
    cycles = 0;
    while (!done && cycles < limit) begin tick(1); cycles++; end
    done_cyc = cyc;
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    e = (exp_err.size() != 0) ? exp_err.pop_front() : 2'bxx;
    check({tag, "_err_code"}, 32'(err_code), 32'(e));
    tick(1);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  // Device model: waits for request-to-send, then produces nfalls clock falls,
  // sampling the host data line at the end of each low phase.
  task automatic dev(input int nfalls, input bit ack, input bit glitch_en,
                     input int pulse_at, input int reset_at);
    int w = 0;
    logic e;
    while (!(ps2data_oe && !ps2clk_oe) && w < 5000) begin tick(1); w++; end
    check("dev_rts", 32'(ps2data_oe && !ps2clk_oe), 32'd1);
    if (w >= 5000) return;
    tick(20);
    for (int k = 1; k <= nfalls; k++) begin
      dev_clk_low = 1'b1;
      if (k == 5) fall5_cyc = cyc;
      if (k == reset_at) begin
        tick(20);
        check("pre_reset_data_oe", 32'(ps2data_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_clk_oe", 32'(ps2clk_oe), 32'd0);
        check("rst_data_oe", 32'(ps2data_oe), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        tick(5);
        dev_clk_low = 1'b0;
        rst_n = 1'b1;
        return;
      end
      if (k == pulse_at) begin
        tick(20);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        check("shift_tx_ready", 32'(tx_ready), 32'd0);
        tick(1);
        tx_valid = 1'b0;
        tick(HALF - 21);
      end else begin
        tick(HALF);
      end
      if (k <= 10) begin
        e = (exp_bits.size() != 0) ? exp_bits.pop_front() : 1'bx;
        check($sformatf("frame_bit%0d", k), 32'(ps2data_i), 32'(e));
      end
      if (k == 10 && ack) dev_data_low = 1'b1;
      if (k == 11) dev_data_low = 1'b0;
      dev_clk_low = 1'b0;
      if (k < 11) begin
        if (glitch_en) begin
          tick(HALF / 2);
          glitch = 1'b1;
          tick(2);
          glitch = 1'b0;
          tick(HALF / 2 - 2);
        end else begin
          tick(HALF);
        end
      end
    end
  endtask

  initial begin
    int c, w, d0;
    rst_n    = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    tick(3);
    check("reset_tx_ready", 32'(tx_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err_code), 32'd0);
    check("reset_clk_oe", 32'(ps2clk_oe), 32'd0);
    check("reset_data_oe", 32'(ps2data_oe), 32'd0);
    rst_n = 1'b1;
    tick(5);

    // 0xED with ACK
    push_frame(8'hED);
    exp_err.push_back(2'b00);
    send(8'hED);
    check("ed_busy", 32'(busy), 32'd1);
    fork
      dev(11, 1'b1, 1'b0, 0, 0);
      wait_done("ed", 8000, c);
    join
    check("ed_clk_hold_min", 32'(last_clk_low >= INH), 32'd1);
    check("ed_start_low", 32'(last_both_low), 32'(US));
    check("ed_idle_ready", 32'(tx_ready), 32'd1);
    tick(10);

    // 0x00 without ACK
    push_frame(8'h00);
    exp_err.push_back(2'b11);
    send(8'h00);
    fork
      dev(11, 1'b0, 1'b0, 0, 0);
      wait_done("noack", 8000, c);
    join
    check("noack_clk_oe", 32'(ps2clk_oe), 32'd0);
    check("noack_data_oe", 32'(ps2data_oe), 32'd0);
    tick(10);

    // 0xFF with no device: first-edge timeout measured from clock release
    exp_err.push_back(2'b01);
    send(8'hFF);
    w = 0;
    while (ps2clk_oe && w < 1000) begin tick(1); w++; end
    wait_done("first_to", FIRST + 100, c);
    check("first_to_time", 32'(c >= FIRST - 2 && c <= FIRST + 2), 32'd1);
    check("first_to_clk_oe", 32'(ps2clk_oe), 32'd0);
    check("first_to_data_oe", 32'(ps2data_oe), 32'd0);
    tick(10);

    // device stalls after fall 5
    push_frame(8'h3C);
    exp_err.push_back(2'b10);
    send(8'h3C);
    fork
      dev(5, 1'b0, 1'b0, 0, 0);
      wait_done("bit_to", BITC + 2000, c);
    join
    check("bit_to_time", 32'((done_cyc - fall5_cyc) >= BITC && (done_cyc - fall5_cyc) <= BITC + 15), 32'd1);
    check("bit_to_data_oe", 32'(ps2data_oe), 32'd0);
    exp_bits.delete();
    tick(10);

    // requests ignored while busy, then reset mid-frame at fall 6
    push_frame(8'h5A);
    send(8'h5A);
    d0 = done_cnt;
    fork
      dev(11, 1'b1, 1'b0, 3, 6);
      begin
        tick(50);
        check("inh_clk_oe", 32'(ps2clk_oe), 32'd1);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        check("inh_tx_ready", 32'(tx_ready), 32'd0);
        tick(1);
        tx_valid = 1'b0;
      end
    join
    tick(20);
    check("rst_no_done", 32'(done_cnt), 32'(d0));
    check("post_rst_busy", 32'(busy), 32'd0);
    exp_bits.delete();

    // 0xA5 with 2-cycle clock glitches
    push_frame(8'hA5);
    exp_err.push_back(2'b00);
    send(8'hA5);
    fork
      dev(11, 1'b1, 1'b1, 0, 0);
      wait_done("glitch", 8000, c);
    join
    check("glitch_queue_empty", 32'(exp_bits.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte from the FPGA to a keyboard or mouse on the same clkps2/dataps2 pair the receive path listens to (e.g. 0xED set-LEDs, 0xFF reset).
- Drives both lines open-drain, so the top level provides tri-state pads: line driven low when oe=1, released (pulled up) otherwise.
- Runs on the 25 MHz pixel clock domain.
- Reports completion, device ACK and timeout status to the controlling logic.

Parameters:
- CLK_FREQ_HZ, 25000000, system clock frequency; all timings derive from it. US = CLK_FREQ_HZ/1000000.
- INHIBIT_US, 120, time the host holds clock low before the request.
- FIRST_EDGE_MS, 15, maximum wait for the device's first clock falling edge after the request.
- BIT_TIMEOUT_US, 2000, maximum gap between consecutive device clock falling edges.
- FILTER_LEN, 4, consecutive equal samples needed to accept a line level change.

Ports:
- clk, in, 1, system clock (25 MHz).
- rst_n, in, 1, asynchronous active-low reset.
- tx_data, in, 8, byte to send.
- tx_valid, in, 1, request; accepted when tx_valid & tx_ready.
- tx_ready, out, 1, high only in IDLE.
- busy, out, 1, high from acceptance until done.
- done, out, 1, one-cycle pulse at end of every accepted transfer.
- err_code, out, 2, valid with done: 00 ACK ok, 01 first-edge timeout, 10 bit timeout, 11 no ACK; held until next acceptance.
- ps2clk_i, in, 1, raw clock pad level (asynchronous).
- ps2data_i, in, 1, raw data pad level (asynchronous).
- ps2clk_oe, out, 1, 1 = drive clock line low.
- ps2data_oe, out, 1, 1 = drive data line low.

Behaviour:
- Reset (asynchronous, immediate): state IDLE, both oe=0, tx_ready=1, busy=0, done=0, err_code=00, filters preset to 1.
- Input conditioning: 2-FF synchroniser per line, then a FILTER_LEN agreement filter. A device-clock fall is a single-cycle event when filtered clock goes 1 to 0.
- Acceptance: latch tx_data and compute parity = ~^tx_data (odd). Set bit counter n=0. Go to INHIBIT on the next cycle.
- INHIBIT: clk_oe=1 for INHIBIT_US*US cycles, then REQ.
- REQ: clk_oe=1 and data_oe=1 (start bit) for US cycles. Then clk_oe=0, clear timer, go to SHIFT.
- SHIFT: wait for a device-clock fall.
  - Fall number 1..8: data_oe = ~tx_data[n-1], LSB first.
  - Fall 9: data_oe = ~parity.
  - Fall 10: data_oe=0 (stop bit = 1), go to ACK.
  - data_oe changes on the cycle after the fall event.
  - Timer is cleared on each fall.
  - Timeout limit: FIRST_EDGE_MS*1000*US cycles before the first fall (error 01); BIT_TIMEOUT_US*US cycles between later falls (error 10).
- ACK: on the 11th fall, sample filtered data. 0 means ACK ok (code 00), 1 means no ACK (code 11). Go to RELEASE.
  - Timeout in ACK gives code 10.
- RELEASE: wait until filtered clock and data are both 1, bounded by the bit timeout (code 10 if exceeded). Then DONE.
- DONE: done=1 for one cycle, err_code updated, back to IDLE.
- Any timeout: release both lines that cycle, then go to DONE with the code.
- Both oe are 0 in every state except INHIBIT, REQ and the data_oe cases above.
- tx_valid while busy is ignored; no queueing.
- Clock falls seen in IDLE (device-to-host traffic) are ignored.
- Timer width must cover 15 ms at 25 MHz: 375000 cycles, 19 bits minimum.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and ACKing. Data bits after falls 1-8 are 1,0,1,1,0,1,1,1; parity 1; stop 1. Expect done with err_code=00. Check clock held low at least 3000 cycles and data low 25 cycles before clock release.
- Send 0x00 with the device not ACKing at fall 11. Expect parity bit 1, done with err_code=11, both oe=0 afterwards.
- Send 0xFF with no device clock at all. Expect done exactly 375000 cycles (±2) after clock release, err_code=01, lines released.
- Device stops clocking after fall 5. Expect err_code=10 about 50000 cycles after fall 5, data_oe=0.
- Pulse tx_valid at INHIBIT and at SHIFT. Expect it ignored with tx_ready=0. Assert rst_n low at fall 6: both oe=0 and tx_ready=1 within the same cycle, no done pulse.
- Inject 2-cycle glitches on ps2clk_i during SHIFT. Expect no bit advance; transfer of 0xA5 still completes with code 00.
